// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample framer and its frame bank.
package fft_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } framer_state_e;

  localparam int DEFAULT_SAMPLES = 16;
  localparam int DEFAULT_WIDTH   = 3;

  // Width of a sample index; never narrower than one bit.
  function automatic int idx_width(input int samples);
    return (samples > 2) ? $clog2(samples) : 1;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// SAMPLES x WIDTH register file: one indexed write port, full parallel read-out.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int SAMPLES = DEFAULT_SAMPLES,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [idx_width(SAMPLES)-1:0] wr_idx_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  output logic [WIDTH-1:0]              rd_data_o [SAMPLES-1:0]
);

  logic [WIDTH-1:0] mem_q [SAMPLES-1:0];

  // NOTE: the buffer is reset on purpose so a discarded frame never leaks out;
  // this costs a reset pin per flop, which is why memories are usually left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLES; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q;

endmodule

// File: rtl/fft_sample_framer.sv
// Collects serial samples into SAMPLES-long frames for the FFT reorder stage.
// Define FFT_FRAMER_PINGPONG_EN for a second bank so filling continues while a frame is presented.
module fft_sample_framer
  import fft_pkg::*;
#(
  parameter int SAMPLES = DEFAULT_SAMPLES,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [7:0]       frame_count
);

  localparam int               IDX_W    = idx_width(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             accept;
  logic             frame_done;

  assign accept     = sample_valid && sample_ready;
  assign frame_done = accept && (wr_idx_q == LAST_IDX);

  // SAMPLES is a power of two, so the index wraps to 0 on its own after the last sample.
  always_comb begin
    wr_idx_d      = accept ? wr_idx_q + 1'b1 : wr_idx_q;
    frame_count_d = frame_done ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      wr_idx_q      <= wr_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;

`ifdef FFT_FRAMER_PINGPONG_EN
  // wr_bank_q: bank being filled; rd_bank_q: oldest full bank, the one presented.
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [WIDTH-1:0] bank0_data [SAMPLES-1:0];
  logic [WIDTH-1:0] bank1_data [SAMPLES-1:0];

  assign sample_ready = ~&full_q;
  assign frame_valid  = full_q[rd_bank_q];

  // Ack and completion are applied independently, so a same-edge pair hands over with no gap.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (frame_valid && frame_ack) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept && !wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (sample_in),
    .rd_data_o (bank0_data)
  );

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept && wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (sample_in),
    .rd_data_o (bank1_data)
  );

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      frame_out[i] = rd_bank_q ? bank1_data[i] : bank0_data[i];
    end
  end
`else
  framer_state_e state_q, state_d;

  // Both outputs decode the state register only, keeping sample_ready free of input paths.
  assign sample_ready = (state_q == FILL);
  assign frame_valid  = (state_q == HOLD);

  // NOTE: assigning state_d before the case gives every path a value, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (frame_done) state_d = HOLD;
      HOLD:    if (frame_ack)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (sample_in),
    .rd_data_o (frame_out)
  );
`endif

endmodule
